// File: rtl/axi_master_cmd_arbiter_pkg.sv
// rtl/axi_master_cmd_arbiter_pkg.sv - shared types and constants for the axi_master command arbiter
package axi_master_cmd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int LEN_W      = 9;
    localparam int MLEN_W     = 8;
    localparam int LEN_SAT    = 256;
    // Requester index occupies the low ID bits; ID_TAG fills everything above it.
    localparam int ID_IDX_LSB = 0;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Beat count to AXI burst length: 0 behaves as 1, anything past LEN_SAT clamps.
    function automatic logic [MLEN_W-1:0] burst_len(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return '0;
        end else if (int'(len) >= LEN_SAT) begin
            return '1;
        end else begin
            return MLEN_W'(len - 1'b1);
        end
    endfunction

endpackage

// File: rtl/axi_master_cmd_arbiter_rr_arbiter.sv
// rtl/axi_master_cmd_arbiter_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
    import axi_master_cmd_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/axi_master_cmd_arbiter.sv
// rtl/axi_master_cmd_arbiter.sv - round-robin scheduler sharing one axi_master command port
module axi_master_cmd_arbiter
    import axi_master_cmd_arbiter_pkg::*;
#(
    parameter int  NUM_REQ         = 4,
    parameter int  MSTR_ADDR_WIDTH = 32,
    parameter int  MSTR_ID_WIDTH   = 4,
    parameter int  ID_TAG          = 0,
    parameter int  BUSY_TIMEOUT    = 16,
    localparam int IDX_W           = idx_width(NUM_REQ)
) (
    input  logic                         i_axi_clk,
    input  logic                         i_axi_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ-1:0]           i_req_rnw,
    input  logic [NUM_REQ-1:0]           i_req_en_strb,
    input  logic [NUM_REQ*MSTR_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]     i_req_len,
    output logic [NUM_REQ-1:0]           o_gnt,
    output logic [NUM_REQ-1:0]           o_done,
    output logic                         o_id_err,
    output logic                         o_timeout,
    output logic                         o_active_valid,
    output logic [IDX_W-1:0]             o_active_idx,
    output logic                         o_m_start_read_stb,
    output logic                         o_m_start_write_stb,
    output logic                         o_m_en_strb,
    output logic [MSTR_ID_WIDTH-1:0]     o_m_id,
    output logic [MSTR_ADDR_WIDTH-1:0]   o_m_addr,
    output logic [MLEN_W-1:0]            o_m_data_len,
    input  logic                         i_m_ready,
    input  logic [MSTR_ID_WIDTH-1:0]     i_m_resp_id
);

    localparam int CNT_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam int TAG_SHIFT = ID_TAG << (ID_IDX_LSB + IDX_W);
    localparam logic [MSTR_ID_WIDTH-1:0] TAG_BITS = TAG_SHIFT[MSTR_ID_WIDTH-1:0];

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_REQ-1:0]         gnt_q, gnt_d;
    logic                       rnw_q, rnw_d;
    logic                       en_strb_q, en_strb_d;
    logic [MSTR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MLEN_W-1:0]          dlen_q, dlen_d;
    logic [MSTR_ID_WIDTH-1:0]   id_q, id_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;
    logic                       id_err_q, id_err_d;

    logic [NUM_REQ-1:0]         win_gnt;
    logic [IDX_W-1:0]           win_idx;
    logic                       win_valid;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req_i   (i_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (win_gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            rnw_q     <= 1'b0;
            en_strb_q <= 1'b0;
            addr_q    <= '0;
            dlen_q    <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            id_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            rnw_q     <= rnw_d;
            en_strb_q <= en_strb_d;
            addr_q    <= addr_d;
            dlen_q    <= dlen_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            id_err_q  <= id_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        rnw_d     = rnw_q;
        en_strb_d = en_strb_q;
        addr_d    = addr_q;
        dlen_d    = dlen_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        id_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The completion cycle is spent idle so a finished requester never gets back-to-back grants.
                if (i_m_ready && win_valid && !done_q) begin
                    state_d   = ST_ISSUE;
                    idx_d     = win_idx;
                    gnt_d     = win_gnt;
                    rnw_d     = i_req_rnw[win_idx];
                    en_strb_d = i_req_en_strb[win_idx];
                    addr_d    = i_req_addr[win_idx*MSTR_ADDR_WIDTH +: MSTR_ADDR_WIDTH];
                    dlen_d    = burst_len(i_req_len[win_idx*LEN_W +: LEN_W]);
                    id_d      = TAG_BITS | (MSTR_ID_WIDTH'(win_idx) << ID_IDX_LSB);
                end
            end
            ST_ISSUE: begin
                state_d  = ST_WAIT_BUSY;
                cnt_d    = '0;
                rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            ST_WAIT_BUSY: begin
                if (!i_m_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (i_m_ready) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    id_err_d = (i_m_resp_id != id_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_gnt               = (state_q == ST_ISSUE) ? gnt_q : '0;
    assign o_done              = done_q ? gnt_q : '0;
    assign o_id_err            = id_err_q;
    assign o_timeout           = timeout_q;
    assign o_active_valid      = (state_q != ST_IDLE);
    assign o_active_idx        = idx_q;
    assign o_m_start_read_stb  = (state_q == ST_ISSUE) && rnw_q;
    assign o_m_start_write_stb = (state_q == ST_ISSUE) && !rnw_q;
    assign o_m_en_strb         = en_strb_q;
    assign o_m_id              = id_q;
    assign o_m_addr            = addr_q;
    assign o_m_data_len        = dlen_q;

endmodule

// File: tb/tb_axi_master_cmd_arbiter.sv
// tb/tb_axi_master_cmd_arbiter.sv - self-checking bench for axi_master_cmd_arbiter
module tb_axi_master_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int BT = 16;
    localparam int XW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, rnw, ens;
    logic [N*AW-1:0] addr_bus;
    logic [N*9-1:0]  len_bus;
    logic            m_ready;
    logic [IW-1:0]   resp_id;
    logic [N-1:0]    gnt, done;
    logic            id_err, tmo, act_v;
    logic [XW-1:0]   act_idx;
    logic            rd_stb, wr_stb, m_ens;
    logic [IW-1:0]   m_id;
    logic [AW-1:0]   m_addr;
    logic [7:0]      m_len;
    logic [59:0]     all_outs;

    logic [AW-1:0]   f_addr [N];
    logic [8:0]      f_len  [N];
    int              lens   [5] = '{0, 1, 256, 300, 511};
    int              exp_dl [5] = '{0, 0, 255, 255, 255};

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;

    always #5 clk = ~clk;

    always_comb begin
        addr_bus = '0;
        len_bus  = '0;
        for (int k = 0; k < N; k++) begin
            addr_bus[k*AW +: AW] = f_addr[k];
            len_bus[k*9 +: 9]    = f_len[k];
        end
    end

    assign all_outs = {gnt, done, id_err, tmo, act_v, act_idx, rd_stb, wr_stb, m_ens, m_id, m_addr, m_len};

    axi_master_cmd_arbiter dut (
        .i_axi_clk           (clk),
        .i_axi_rst           (rst_n),
        .i_req               (req),
        .i_req_rnw           (rnw),
        .i_req_en_strb       (ens),
        .i_req_addr          (addr_bus),
        .i_req_len           (len_bus),
        .o_gnt               (gnt),
        .o_done              (done),
        .o_id_err            (id_err),
        .o_timeout           (tmo),
        .o_active_valid      (act_v),
        .o_active_idx        (act_idx),
        .o_m_start_read_stb  (rd_stb),
        .o_m_start_write_stb (wr_stb),
        .o_m_en_strb         (m_ens),
        .o_m_id              (m_id),
        .o_m_addr            (m_addr),
        .o_m_data_len        (m_len),
        .i_m_ready           (m_ready),
        .i_m_resp_id         (resp_id)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_len(input int l);
        if (l == 0) return 0;
        if (l > 256) return 255;
        return l - 1;
    endfunction

    function automatic int winner(input logic [N-1:0] rv, input int p);
        for (int i = 0; i < N; i++) begin
            if (rv[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    // Ready trace relative to the strobe cycle S: high until S+a, low for b cycles, then high.
    task automatic run_cmd(input logic [N-1:0] rv, input logic [N-1:0] keep, input int a, input int b,
                           input int resp, input int lat, output int dut_idx);
        int w, got, expd, rid;
        bit to;
        logic [N-1:0] onehot;
        w = winner(rv, exp_ptr);
        onehot = '0;
        onehot[w] = 1'b1;
        req = rv;
        m_ready = 1'b1;
        got = 0;
        do begin
            @(posedge clk); #1;
            got++;
        end while (gnt == '0 && got < 12);
        dut_idx = int'(act_idx);
        check("gnt_latency", got, lat);
        check("gnt_onehot", gnt, onehot);
        check("read_stb", rd_stb, rnw[w]);
        check("write_stb", wr_stb, !rnw[w]);
        check("m_addr", m_addr, f_addr[w]);
        check("m_data_len", m_len, exp_len(int'(f_len[w])));
        check("m_id", m_id, w);
        check("m_en_strb", m_ens, ens[w]);
        check("active_idx", act_idx, w);
        check("active_valid", act_v, 1);
        exp_ptr = (w + 1) % N;
        req[w] = keep[w];
        rid = (resp < 0) ? w : resp;
        to = ((a - 1) >= BT);
        expd = to ? BT + 1 : a + b + 1;
        for (int c = 1; c <= expd; c++) begin
            @(posedge clk); #1;
            m_ready = (c >= a && c < a + b) ? 1'b0 : 1'b1;
            resp_id = IW'(rid);
            check("done", done, (c == expd) ? onehot : {N{1'b0}});
            if (c == 1) check("strobe_width", {gnt, rd_stb, wr_stb}, '0);
            if (c == expd) begin
                check("timeout", tmo, to);
                check("id_err", id_err, (!to && rid != w));
                check("idle_after_done", act_v, 0);
            end
        end
    endtask

    initial begin
        int w;
        int got;
        logic [N-1:0] rv;

        rst_n = 1'b0;
        req = '0;
        rnw = '0;
        ens = '0;
        m_ready = 1'b1;
        resp_id = '0;
        for (int k = 0; k < N; k++) begin
            f_addr[k] = '0;
            f_len[k]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", all_outs, '0);

        for (int k = 0; k < N; k++) begin
            rnw[k]    = 1'(k % 2);
            ens[k]    = 1'((k + 1) % 2);
            f_addr[k] = AW'(32'h100 * (k + 1));
            f_len[k]  = 9'(k + 2);
        end
        for (int i = 0; i < 5; i++) begin
            run_cmd(4'hF, 4'hF, 2, 3, -1, (i == 0) ? 1 : 2, w);
            check("rr_order", w, i % N);
        end

        rnw[2] = 1'b0;
        ens[2] = 1'b1;
        f_addr[2] = 32'h0000_1000;
        f_len[2]  = 9'd4;
        run_cmd(4'b0100, 4'b0000, 2, 10, -1, 2, w);
        check("single_len", m_len, 3);
        check("single_id", m_id, 2);

        for (int i = 0; i < 5; i++) begin
            f_len[1] = 9'(lens[i]);
            run_cmd(4'b0010, 4'b0000, 1, 1, -1, 2, w);
            check("len_edge_hold", m_len, exp_dl[i]);
        end

        run_cmd(4'b0010, 4'b0000, 2, 2, 3, 2, w);

        run_cmd(4'b0001, 4'b0000, 17, 2, -1, 2, w);
        run_cmd(4'b0001, 4'b0000, 16, 2, -1, 2, w);
        run_cmd(4'b1000, 4'b0000, 3, 2, -1, 2, w);

        req = 4'b0100;
        m_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("ready_gating", gnt, '0);
        end
        run_cmd(4'b0100, 4'b0000, 2, 2, -1, 1, w);

        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k]) begin
                    rnw[k]    = 1'($urandom_range(0, 1));
                    ens[k]    = 1'($urandom_range(0, 1));
                    f_addr[k] = $urandom;
                    f_len[k]  = 9'($urandom_range(0, 511));
                end
            end
            rv = req | N'($urandom_range(1, 15));
            run_cmd(rv, 4'b0000, int'($urandom_range(1, 20)), int'($urandom_range(1, 5)),
                    ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 15)), 2, w);
        end

        req = 4'b0100;
        m_ready = 1'b1;
        got = 0;
        do begin
            @(posedge clk); #1;
            got++;
        end while (gnt == '0 && got < 12);
        check("pre_reset_gnt", gnt, 4'b0100);
        req = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in_wait_done", act_v, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs, '0);
        m_ready = 1'b1;
        req = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
            check("no_done_in_reset", {done, gnt}, '0);
        end
        rst_n = 1'b1;
        exp_ptr = 0;
        run_cmd(4'hF, 4'b0000, 2, 2, -1, 1, w);
        check("post_reset_first", w, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
